// File: rtl/sram_arbiter_if.sv
// Loader, game-core and SRAM pin bundle for sram_arbiter.
// The arbiter connects through the master modport. The environment (pins, loader, core) connects through slave.
interface sram_arbiter_if;
  logic        ldr_req;
  logic [18:0] ldr_addr;
  logic [7:0]  ldr_data;
  logic        ldr_ack;
  logic [18:0] core_addr;
  logic [7:0]  core_data;
  logic [18:0] sram_addr;
  logic [7:0]  sram_dout;
  logic        sram_doe;
  logic [7:0]  sram_din;
  logic        sram_we_n;
  logic [7:0]  videoconfig;
  logic        cfg_done;
  logic        core_reset;

  modport master (
    input  ldr_req, ldr_addr, ldr_data, core_addr, sram_din,
    output ldr_ack, core_data, sram_addr, sram_dout, sram_doe, sram_we_n,
           videoconfig, cfg_done, core_reset
  );

  modport slave (
    output ldr_req, ldr_addr, ldr_data, core_addr, sram_din,
    input  ldr_ack, core_data, sram_addr, sram_dout, sram_doe, sram_we_n,
           videoconfig, cfg_done, core_reset
  );
endinterface

// File: rtl/sram_arbiter.sv
// Single-port SRAM arbiter: the power-on config byte read, the game-core ROM reads, and the loader writes.
// While the loader owns the SRAM, and for RST_HOLD cycles after its last write, the game core is kept in reset.
module sram_arbiter #(
  parameter logic [18:0] CFG_ADDR  = 19'h08FD5,
  parameter int unsigned CFG_DELAY = 32,
  parameter int unsigned WR_PULSE  = 2,
  parameter int unsigned RST_HOLD  = 255
) (
  input  logic           clk,
  input  logic           reset,
  sram_arbiter_if.master bus
);
  localparam int unsigned CNT_MAX = (CFG_DELAY > WR_PULSE) ? CFG_DELAY : WR_PULSE;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned HOLD_W  = $clog2(RST_HOLD + 1);
  localparam logic [CNT_W-1:0]  CFG_LAST   = CNT_W'(CFG_DELAY - 1);
  localparam logic [CNT_W-1:0]  PULSE_LAST = CNT_W'(WR_PULSE - 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD  = HOLD_W'(RST_HOLD);

  typedef enum logic [2:0] {
    S_CFG_WAIT, S_CFG_LATCH, S_READ, S_WR_SETUP, S_WR_PULSE, S_WR_HOLD
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [18:0]         wr_addr_q, wr_addr_d;
  logic [7:0]          wr_data_q, wr_data_d;
  logic [7:0]          core_data_q, core_data_d;
  logic [7:0]          videoconfig_q, videoconfig_d;
  logic                cfg_done_q, cfg_done_d;
  logic                ldr_ack_q, ldr_ack_d;
  logic                core_reset_q, core_reset_d;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    hold_d        = hold_q;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    core_data_d   = core_data_q;
    videoconfig_d = videoconfig_q;
    cfg_done_d    = cfg_done_q;
    case (state_q)
      S_CFG_WAIT: begin
        if (cnt_q == CFG_LAST) begin
          state_d = S_CFG_LATCH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_CFG_LATCH: begin
        videoconfig_d = bus.sram_din;
        cfg_done_d    = 1'b1;
        state_d       = S_READ;
      end
      S_READ: begin
        core_data_d = bus.sram_din;
        if (hold_q != '0) hold_d = hold_q - HOLD_W'(1);
        // The write address and data are captured here, so a loader that changes them mid-write has no effect.
        if (bus.ldr_req) begin
          state_d   = S_WR_SETUP;
          wr_addr_d = bus.ldr_addr;
          wr_data_d = bus.ldr_data;
        end
      end
      S_WR_SETUP: begin
        state_d = S_WR_PULSE;
        cnt_d   = '0;
      end
      S_WR_PULSE: begin
        if (cnt_q == PULSE_LAST) begin
          state_d = S_WR_HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WR_HOLD: begin
        hold_d  = HOLD_LOAD;
        state_d = S_READ;
      end
      default: state_d = S_CFG_WAIT;
    endcase
    // These flags are registered from next-state terms, so each output lines up with the state it describes.
    ldr_ack_d    = (state_d == S_WR_HOLD);
    core_reset_d = (state_d != S_READ) || (hold_d != '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_CFG_WAIT;
      cnt_q         <= '0;
      hold_q        <= '0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      core_data_q   <= '0;
      videoconfig_q <= '0;
      cfg_done_q    <= 1'b0;
      ldr_ack_q     <= 1'b0;
      core_reset_q  <= 1'b1;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      hold_q        <= hold_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      core_data_q   <= core_data_d;
      videoconfig_q <= videoconfig_d;
      cfg_done_q    <= cfg_done_d;
      ldr_ack_q     <= ldr_ack_d;
      core_reset_q  <= core_reset_d;
    end
  end

  // The SRAM pins are decoded only from the state register and the latched write values.
  always_comb begin
    bus.sram_addr = CFG_ADDR;
    bus.sram_doe  = 1'b0;
    bus.sram_we_n = 1'b1;
    case (state_q)
      S_READ: bus.sram_addr = bus.core_addr;
      S_WR_SETUP, S_WR_HOLD: begin
        bus.sram_addr = wr_addr_q;
        bus.sram_doe  = 1'b1;
      end
      S_WR_PULSE: begin
        bus.sram_addr = wr_addr_q;
        bus.sram_doe  = 1'b1;
        bus.sram_we_n = 1'b0;
      end
      default: ;
    endcase
  end

  assign bus.sram_dout   = wr_data_q;
  assign bus.core_data   = core_data_q;
  assign bus.videoconfig = videoconfig_q;
  assign bus.cfg_done    = cfg_done_q;
  assign bus.ldr_ack     = ldr_ack_q;
  assign bus.core_reset  = core_reset_q;
endmodule

// File: tb/tb_sram_arbiter.sv
// Testbench for sram_arbiter. The stimulus thread queues the expected config bytes and writes.
// The monitor thread pops those expectations when cfg_done rises or ldr_ack pulses.
module tb_sram_arbiter;
  localparam logic [18:0] CFG_ADDR = 19'h08FD5;

  typedef struct packed {
    logic [18:0] addr;
    logic [7:0]  data;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  cfg_byte;
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  wr_t         exp_wr_q[$];
  logic [7:0]  exp_cfg_q[$];
  logic [18:0] rd_addrs[4];

  sram_arbiter_if bus();

  sram_arbiter #(
    .CFG_ADDR (19'h08FD5),
    .CFG_DELAY(32),
    .WR_PULSE (2),
    .RST_HOLD (255)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // SRAM model: the config location returns cfg_byte, and every other address reads back its low byte.
  always_comb bus.sram_din = (bus.sram_addr == CFG_ADDR) ? cfg_byte : bus.sram_addr[7:0];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event with empty expectation queue at %0t", name, $time);
  endtask

  task automatic push_wr(input logic [18:0] a, input logic [7:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    exp_wr_q.push_back(w);
  endtask

  // Monitor
  logic        prev_cfg = 1'b0;
  logic        prev_we  = 1'b1;
  logic [18:0] cap_addr;
  logic [7:0]  cap_data;
  int unsigned pulse_len = 0;
  wr_t         e_wr;
  logic [7:0]  e_cfg;

  initial forever begin
    @(negedge clk);
    if (bus.cfg_done === 1'b1 && !prev_cfg) begin
      if (exp_cfg_q.size() == 0) unexpected("cfg_done_rise");
      else begin
        e_cfg = exp_cfg_q.pop_front();
        chk("videoconfig", 32'(bus.videoconfig), 32'(e_cfg));
      end
    end
    prev_cfg = (bus.cfg_done === 1'b1);

    if (bus.sram_we_n === 1'b0) begin
      chk("doe_while_we_low", 32'(bus.sram_doe), 1);
      if (prev_we) begin
        cap_addr  = bus.sram_addr;
        cap_data  = bus.sram_dout;
        pulse_len = 1;
      end else begin
        pulse_len++;
        chk("addr_stable_while_we_low", 32'(bus.sram_addr), 32'(cap_addr));
      end
    end
    prev_we = (bus.sram_we_n !== 1'b0);

    if (bus.ldr_ack === 1'b1) begin
      if (exp_wr_q.size() == 0) unexpected("ldr_ack");
      else begin
        e_wr = exp_wr_q.pop_front();
        chk("wr_addr", 32'(cap_addr), 32'(e_wr.addr));
        chk("wr_data", 32'(cap_data), 32'(e_wr.data));
        chk("we_pulse_len", pulse_len, 2);
        chk("hold_addr", 32'(bus.sram_addr), 32'(e_wr.addr));
        chk("ack_core_reset", 32'(bus.core_reset), 1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Stimulus
  initial begin
    int unsigned first_we, ack_cyc, cnt, bad, seen_doe, acks, gap, low_cr;
    logic        found;
    logic [7:0]  held_cd;

    rd_addrs[0] = 19'd0;
    rd_addrs[1] = 19'd1;
    rd_addrs[2] = 19'd2;
    rd_addrs[3] = 19'h7FF80;
    reset         = 1'b1;
    bus.ldr_req   = 1'b0;
    bus.ldr_addr  = '0;
    bus.ldr_data  = '0;
    bus.core_addr = '0;
    cfg_byte      = 8'h03;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_sram_addr",   32'(bus.sram_addr), 32'(CFG_ADDR));
    chk("rst_we_n",        32'(bus.sram_we_n), 1);
    chk("rst_doe",         32'(bus.sram_doe), 0);
    chk("rst_cfg_done",    32'(bus.cfg_done), 0);
    chk("rst_videoconfig", 32'(bus.videoconfig), 0);
    chk("rst_core_data",   32'(bus.core_data), 0);
    chk("rst_ldr_ack",     32'(bus.ldr_ack), 0);
    chk("rst_core_reset",  32'(bus.core_reset), 1);

    // Power-on config read, with an early loader request from cycle 5.
    exp_cfg_q.push_back(8'h03);
    reset    = 1'b0;
    first_we = 0;
    ack_cyc  = 0;
    bad      = 0;
    for (int i = 1; i <= 60 && ack_cyc == 0; i++) begin
      @(negedge clk);
      if (i <= 32 && (bus.sram_addr !== CFG_ADDR || bus.cfg_done !== 1'b0 ||
                      bus.core_reset !== 1'b1 || bus.sram_we_n !== 1'b1)) bad++;
      if (i == 33) chk("cfg_done_cycle33", 32'(bus.cfg_done), 1);
      if (i == 5) begin
        bus.ldr_req  = 1'b1;
        bus.ldr_addr = 19'h12345;
        bus.ldr_data = 8'h5A;
        push_wr(19'h12345, 8'h5A);
      end
      if (bus.sram_we_n === 1'b0 && first_we == 0) first_we = i;
      if (bus.ldr_ack === 1'b1) begin
        ack_cyc     = i;
        bus.ldr_req = 1'b0;
      end
    end
    chk("cfg_window_errors", bad, 0);
    chk("early_first_we_cycle", first_we, 35);
    chk("early_ack_cycle", ack_cyc, 37);

    // Hold counter: core_reset stays high for RST_HOLD cycles after WR_HOLD.
    cnt = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (bus.core_reset === 1'b1) cnt++;
      else break;
    end
    chk("core_reset_hold_cycles", cnt, 255);

    // Core reads: read data appears one cycle after the address.
    for (int k = 0; k < 4; k++) begin
      bus.core_addr = rd_addrs[k];
      @(negedge clk);
      chk("core_data", 32'(bus.core_data), 32'(rd_addrs[k][7:0]));
    end
    chk("core_reset_idle", 32'(bus.core_reset), 0);

    // Single write. The loader inputs are scrambled after SETUP to show that the arbiter latched them.
    push_wr(19'h00100, 8'hA5);
    bus.ldr_addr = 19'h00100;
    bus.ldr_data = 8'hA5;
    bus.ldr_req  = 1'b1;
    seen_doe = 0;
    bad      = 0;
    ack_cyc  = 0;
    held_cd  = '0;
    for (int i = 1; i <= 20 && ack_cyc == 0; i++) begin
      @(negedge clk);
      if (bus.sram_doe === 1'b1) begin
        if (bus.sram_addr !== 19'h00100 || bus.sram_dout !== 8'hA5) bad++;
        if (seen_doe == 0) begin
          held_cd      = bus.core_data;
          bus.ldr_addr = 19'h7FFFF;
          bus.ldr_data = 8'h00;
        end else if (bus.core_data !== held_cd) bad++;
        seen_doe++;
      end
      if (bus.ldr_ack === 1'b1) begin
        ack_cyc     = i;
        bus.ldr_req = 1'b0;
      end
    end
    chk("single_ack_cycle", ack_cyc, 4);
    chk("single_doe_cycles", seen_doe, 4);
    chk("single_bus_stable", bad, 0);

    // Back-to-back writes: a request still high after ack gets exactly one READ cycle.
    push_wr(19'h00200, 8'h11);
    push_wr(19'h00201, 8'h22);
    bus.ldr_addr = 19'h00200;
    bus.ldr_data = 8'h11;
    bus.ldr_req  = 1'b1;
    acks   = 0;
    gap    = 0;
    low_cr = 0;
    for (int i = 1; i <= 40 && acks < 2; i++) begin
      @(negedge clk);
      if (bus.core_reset !== 1'b1) low_cr++;
      if (acks == 1 && bus.sram_doe === 1'b0) gap++;
      if (bus.ldr_ack === 1'b1) begin
        acks++;
        if (acks == 1) begin
          bus.ldr_addr = 19'h00201;
          bus.ldr_data = 8'h22;
        end else bus.ldr_req = 1'b0;
      end
    end
    chk("b2b_acks", acks, 2);
    chk("b2b_read_gap", gap, 1);
    chk("b2b_core_reset_low", low_cr, 0);

    // Mid-write reset: the write is abandoned with no ack, and the config sequence restarts.
    bus.ldr_addr = 19'h00300;
    bus.ldr_data = 8'h33;
    bus.ldr_req  = 1'b1;
    found = 1'b0;
    for (int i = 1; i <= 10 && !found; i++) begin
      @(negedge clk);
      if (bus.sram_we_n === 1'b0) found = 1'b1;
    end
    chk("midwr_reached_pulse", 32'(found), 1);
    reset = 1'b1;
    @(negedge clk);
    chk("midwr_we_n",        32'(bus.sram_we_n), 1);
    chk("midwr_doe",         32'(bus.sram_doe), 0);
    chk("midwr_ldr_ack",     32'(bus.ldr_ack), 0);
    chk("midwr_sram_addr",   32'(bus.sram_addr), 32'(CFG_ADDR));
    chk("midwr_cfg_done",    32'(bus.cfg_done), 0);
    chk("midwr_videoconfig", 32'(bus.videoconfig), 0);
    bus.ldr_req = 1'b0;
    cfg_byte    = 8'h5C;
    exp_cfg_q.push_back(8'h5C);
    reset = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 32) chk("restart_cfg_done_32", 32'(bus.cfg_done), 0);
      if (i == 33) chk("restart_cfg_done_33", 32'(bus.cfg_done), 1);
    end

    chk("wr_queue_empty",  exp_wr_q.size(), 0);
    chk("cfg_queue_empty", exp_cfg_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
